// File: rtl/part_tester_pkg.sv
// rtl/part_tester_pkg.sv - shared op/state encodings and part geometry for the part tester
package part_tester_pkg;

  typedef enum logic [1:0] {
    OP_SHIFT = 2'b00,
    OP_EXEC  = 2'b01,
    OP_FREE  = 2'b10,
    OP_NOP   = 2'b11
  } op_t;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SH_SI  = 3'd1,
    ST_SH_SO  = 3'd2,
    ST_CLK_HI = 3'd3,
    ST_CLK_LO = 3'd4,
    ST_DONE   = 3'd5
  } state_t;

  localparam int NREGS = 19;
  localparam int NPIS  = 14;
  localparam int NPOS  = 11;

endpackage

// File: rtl/part_seq_if.sv
// rtl/part_seq_if.sv - command and scan-bit handshakes between command processor and sequencer
interface part_seq_if #(
  parameter int CNT_W = 16
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [1:0]       cmd_op;
  logic [CNT_W-1:0] cmd_count;
  logic             si_valid;
  logic             si_ready;
  logic             si_data;
  logic             so_valid;
  logic             so_ready;
  logic             so_data;

  modport master (
    output cmd_valid, cmd_op, cmd_count, si_valid, si_data, so_ready,
    input  cmd_ready, si_ready, so_valid, so_data
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_count, si_valid, si_data, so_ready,
    output cmd_ready, si_ready, so_valid, so_data
  );
endinterface

// File: rtl/part_clk_gen.sv
// rtl/part_clk_gen.sv - part clock phase counter with end-of-high / end-of-low strobes
module part_clk_gen #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rstn,
  input  logic i_run,
  output logic o_hi_end,
  output logic o_lo_end
);
  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] r_cnt;
  logic          r_hi;
  logic          w_last;

  assign w_last = i_run && (r_cnt == LAST);

  // Idle counter parks at the start of a high phase so every run begins with a full high half-period
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_cnt <= '0;
      r_hi  <= 1'b1;
    end else if (!i_run) begin
      r_cnt <= '0;
      r_hi  <= 1'b1;
    end else if (w_last) begin
      r_cnt <= '0;
      r_hi  <= ~r_hi;
    end else begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

  assign o_hi_end = w_last && r_hi;
  assign o_lo_end = w_last && !r_hi;
endmodule

// File: rtl/part_seq.sv
// rtl/part_seq.sv - turns decoded host commands into cycle-exact part clock, scan-enable and test-mode
module part_seq
  import part_tester_pkg::*;
#(
  parameter int CLK_DIV = 4,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rstn,
  part_seq_if.slave        bus,
  input  logic             stop,
  output logic             part_clk,
  output logic             part_se,
  output logic             part_tm,
  output logic             part_si,
  input  logic             part_so,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] cycles
);
  state_t           r_state, w_state_nxt;
  op_t              r_op, w_op_nxt, w_cmd_op;
  logic [CNT_W-1:0] r_remain, r_cycles;
  logic             r_cmd_ready, r_si_ready, r_so_valid, r_so_data;
  logic             r_part_clk, r_scan, r_part_si, r_busy, r_done;
  logic             w_cmd_ready_nxt, w_si_ready_nxt, w_so_valid_nxt;
  logic             w_clk_nxt, w_scan_nxt, w_busy_nxt, w_done_nxt;
  logic             w_accept, w_run, w_hi_end, w_lo_end, w_last_bit;

  assign w_cmd_op   = op_t'(bus.cmd_op);
  assign w_run      = (r_state == ST_CLK_HI) || (r_state == ST_CLK_LO);
  assign w_last_bit = (r_remain == CNT_W'(1));

  part_clk_gen #(.CLK_DIV(CLK_DIV)) u_clk_gen (
    .clk      (clk),
    .rstn     (rstn),
    .i_run    (w_run),
    .o_hi_end (w_hi_end),
    .o_lo_end (w_lo_end)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state     <= ST_IDLE;
      r_op        <= OP_NOP;
      r_cmd_ready <= 1'b1;
      r_si_ready  <= 1'b0;
      r_so_valid  <= 1'b0;
      r_part_clk  <= 1'b0;
      r_scan      <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_op        <= w_op_nxt;
      r_cmd_ready <= w_cmd_ready_nxt;
      r_si_ready  <= w_si_ready_nxt;
      r_so_valid  <= w_so_valid_nxt;
      r_part_clk  <= w_clk_nxt;
      r_scan      <= w_scan_nxt;
      r_busy      <= w_busy_nxt;
      r_done      <= w_done_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (bus.cmd_valid) begin
          w_accept = 1'b1;
          if (w_cmd_op == OP_NOP || (w_cmd_op != OP_FREE && bus.cmd_count == '0))
            w_state_nxt = ST_DONE;
          else if (w_cmd_op == OP_SHIFT)
            w_state_nxt = ST_SH_SI;
          else
            w_state_nxt = ST_CLK_HI;
        end
      end
      ST_SH_SI:  if (bus.si_valid) w_state_nxt = ST_SH_SO;
      ST_SH_SO:  if (bus.so_ready) w_state_nxt = ST_CLK_HI;
      ST_CLK_HI: if (w_hi_end)     w_state_nxt = ST_CLK_LO;
      ST_CLK_LO: begin
        // stop only counts when sampled in the final low cycle of a FREE pulse
        if (w_lo_end) begin
          case (r_op)
            OP_SHIFT: w_state_nxt = w_last_bit ? ST_DONE : ST_SH_SI;
            OP_EXEC:  w_state_nxt = w_last_bit ? ST_DONE : ST_CLK_HI;
            OP_FREE:  w_state_nxt = stop       ? ST_DONE : ST_CLK_HI;
            default:  w_state_nxt = ST_DONE;
          endcase
        end
      end
      ST_DONE: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    w_op_nxt        = w_accept ? w_cmd_op : r_op;
    w_cmd_ready_nxt = (w_state_nxt == ST_IDLE);
    w_si_ready_nxt  = (w_state_nxt == ST_SH_SI);
    w_so_valid_nxt  = (w_state_nxt == ST_SH_SO);
    w_clk_nxt       = (w_state_nxt == ST_CLK_HI);
    w_done_nxt      = (w_state_nxt == ST_DONE);
    w_busy_nxt      = (w_state_nxt != ST_IDLE);
    w_scan_nxt      = w_busy_nxt && (w_op_nxt == OP_SHIFT);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_remain  <= '0;
      r_cycles  <= '0;
      r_part_si <= 1'b0;
      r_so_data <= 1'b0;
    end else begin
      if (w_accept) begin
        r_remain <= bus.cmd_count;
        r_cycles <= '0;
      end else if (r_state == ST_CLK_LO && w_lo_end) begin
        if (r_cycles != '1) r_cycles <= r_cycles + CNT_W'(1);
        if (r_remain != '0) r_remain <= r_remain - CNT_W'(1);
      end
      // so_data captures the chain output before the shift edge moves it
      if (r_state == ST_SH_SI && bus.si_valid) begin
        r_part_si <= bus.si_data;
        r_so_data <= part_so;
      end
    end
  end

  assign bus.cmd_ready = r_cmd_ready;
  assign bus.si_ready  = r_si_ready;
  assign bus.so_valid  = r_so_valid;
  assign bus.so_data   = r_so_data;
  assign part_clk      = r_part_clk;
  assign part_se       = r_scan;
  assign part_tm       = r_scan;
  assign part_si       = r_part_si;
  assign busy          = r_busy;
  assign done          = r_done;
  assign cycles        = r_cycles;
endmodule
